commit_monitor: RTL and testbench
=================================

COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 Parameter WATCHDOG_CYCLES, default 4096: cycles without a commit before TIMEOUT is declared.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  one instruction retires this cycle.
REQ-005 wb_pc  input  32  PC of retiring instruction.
REQ-006 wb_inst  input  32  encoding of retiring instruction.
REQ-007 wb_rf_we  input  1  retiring instruction writes a GPR.
REQ-008 wb_rf_waddr  input  5  destination GPR index.
REQ-009 wb_rf_wdata  input  32  destination GPR value.
REQ-010 dt_valid  output  1  one-cycle pulse: dt_pc/rf_* describe a completed commit.
REQ-011 dt_pc  output  32  PC of most recently committed instruction.
REQ-012 rf_0 .. rf_31  output  32 each  architectural GPR state after most recent commit.
REQ-013 inst_cnt  output  64  committed-instruction count.
REQ-014 cycle_cnt  output  64  cycles spent in RUN.
REQ-015 halt  output  1  ebreak committed; sticky.
REQ-016 good_trap  output  1  valid while halt=1: x10 was zero at ebreak.
REQ-017 timeout  output  1  watchdog expired; sticky.

Function
REQ-018 States RUN, HALT, TIMEOUT; reset enters RUN.
REQ-019 Commit = wb_valid=1 in RUN; wb_valid in HALT/TIMEOUT ignored entirely.
REQ-020 On commit with wb_rf_we=1 and wb_rf_waddr!=0, shadow GPR[waddr] <= wb_rf_wdata; writes to x0 discarded, rf_0 constant 0.
REQ-021 Latency 1: cycle after a commit, dt_valid=1, dt_pc=wb_pc, rf_* include that commit's write; dt_valid=0 on all other cycles.
REQ-022 inst_cnt +1 per commit; cycle_cnt +1 per cycle in RUN; both wrap modulo 2^64; both frozen outside RUN.
REQ-023 Commit with wb_inst=0x00100073 (ebreak): transition RUN->HALT; halt=1 next cycle; good_trap = (shadow x10 == 0) sampled that cycle; ebreak still counted and still produces dt_valid.
REQ-024 Watchdog counter: cleared on every commit, else +1 per RUN cycle; when it equals WATCHDOG_CYCLES-1 with no commit that cycle, RUN->TIMEOUT, timeout=1 next cycle.
REQ-025 Commit on the expiry cycle wins: counter clears, no TIMEOUT.
REQ-026 HALT and TIMEOUT are terminal; exit only by reset; dt_pc, rf_*, counters hold.
REQ-027 Counter width ceil(log2(WATCHDOG_CYCLES)) bits minimum; WATCHDOG_CYCLES>=2.

Reset
REQ-028 rst_n=0 asynchronously forces: state RUN, dt_valid 0, dt_pc 0x80000000, rf_* 0, inst_cnt 0, cycle_cnt 0, watchdog 0, halt 0, good_trap 0, timeout 0.
REQ-029 Reset asserted mid-commit discards that commit; first commit counted is the first wb_valid sampled after rst_n deasserts.

Structure
REQ-030 Package npc_dbg_pkg holds EBREAK_INST constant, state enum (RUN/HALT/TIMEOUT), reset PC constant, default WATCHDOG_CYCLES.
REQ-031 Sub-module shadow_rf: 31x32 register array, one write port, all entries exposed in parallel, async active-low clear.
REQ-032 Outputs rf_*/dt_pc/dt_valid connect port-for-port to the difftest sink; no combinational path from wb_* to any output.

Verification
REQ-033 Reset, then commit pc=0x80000000 inst=addi x5 (we=1, waddr=5, wdata=0x1234) -> next cycle dt_valid=1, dt_pc=0x80000000, rf_5=0x1234, inst_cnt=1.
REQ-034 Commit we=1 waddr=0 wdata=0xFFFFFFFF -> rf_0=0, dt_valid still pulses, inst_cnt increments.
REQ-035 Write x10=0 then commit inst=0x00100073 -> halt=1, good_trap=1; further wb_valid ignored, inst_cnt and dt_pc frozen; repeat with x10=7 -> good_trap=0.
REQ-036 WATCHDOG_CYCLES=16, no commits after reset -> timeout=1 on cycle 16 after reset release, cycle_cnt=16, halt=0.
REQ-037 WATCHDOG_CYCLES=16, commit exactly on expiry cycle -> no timeout, watchdog restarts, timeout after 16 further idle cycles.
REQ-038 Drop rst_n during back-to-back commits in RUN -> all outputs at reset values immediately, no dt_valid pulse for the aborted commit.

Source files
------------

// File: rtl/npc_dbg_pkg.sv
// Shared constants and state type for the commit monitor.
// Holds the ebreak encoding, reset PC and the default watchdog limit.
package npc_dbg_pkg;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int WATCHDOG_DEFAULT = 4096;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    TIMEOUT
  } state_t;
endpackage

// File: rtl/shadow_rf.sv
// Shadow GPR file x1..x31: one write port, every entry visible in parallel.
// Ports: clk, rst_n (async clear), we/waddr/wdata write port, regs out.
module shadow_rf (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [31:0]       wdata,
  output logic [31:1][31:0] regs
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: shadows GPRs, emits difftest pulses, counts, halts.
// Ports: clk, rst_n, wb_* retire bus in; dt_*, rf_*, counters, status out.
module commit_monitor
  import npc_dbg_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = WATCHDOG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_rf_we,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [31:0] wb_rf_wdata,
  output logic        dt_valid,
  output logic [31:0] dt_pc,
  output logic [31:0] rf_0,
  output logic [31:0] rf_1,
  output logic [31:0] rf_2,
  output logic [31:0] rf_3,
  output logic [31:0] rf_4,
  output logic [31:0] rf_5,
  output logic [31:0] rf_6,
  output logic [31:0] rf_7,
  output logic [31:0] rf_8,
  output logic [31:0] rf_9,
  output logic [31:0] rf_10,
  output logic [31:0] rf_11,
  output logic [31:0] rf_12,
  output logic [31:0] rf_13,
  output logic [31:0] rf_14,
  output logic [31:0] rf_15,
  output logic [31:0] rf_16,
  output logic [31:0] rf_17,
  output logic [31:0] rf_18,
  output logic [31:0] rf_19,
  output logic [31:0] rf_20,
  output logic [31:0] rf_21,
  output logic [31:0] rf_22,
  output logic [31:0] rf_23,
  output logic [31:0] rf_24,
  output logic [31:0] rf_25,
  output logic [31:0] rf_26,
  output logic [31:0] rf_27,
  output logic [31:0] rf_28,
  output logic [31:0] rf_29,
  output logic [31:0] rf_30,
  output logic [31:0] rf_31,
  output logic [63:0] inst_cnt,
  output logic [63:0] cycle_cnt,
  output logic        halt,
  output logic        good_trap,
  output logic        timeout
);

  localparam int WD_W = $clog2(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [WD_W-1:0]  wd;
  logic             trap_ok;
  logic [31:1][31:0] regs;

  logic run;
  logic commit;
  logic is_ebreak;
  logic expire;

  assign run       = (state == RUN);
  assign commit    = wb_valid && run;
  assign is_ebreak = (wb_inst == EBREAK_INST);
  // a commit on the last watchdog cycle rescues the run
  assign expire    = run && !commit && (wd == WD_LAST);

  shadow_rf u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && wb_rf_we),
    .waddr (wb_rf_waddr),
    .wdata (wb_rf_wdata),
    .regs  (regs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      commit && is_ebreak: state_nx = HALT;
      expire:              state_nx = TIMEOUT;
      default:             state_nx = state;
    endcase
  end

  always_comb begin
    halt      = (state == HALT);
    timeout   = (state == TIMEOUT);
    good_trap = halt && trap_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_valid  <= 1'b0;
      dt_pc     <= RESET_PC;
      inst_cnt  <= '0;
      cycle_cnt <= '0;
      wd        <= '0;
      trap_ok   <= 1'b0;
    end else begin
      dt_valid <= commit;
      if (commit) begin
        dt_pc    <= wb_pc;
        inst_cnt <= inst_cnt + 64'd1;
      end
      if (run) cycle_cnt <= cycle_cnt + 64'd1;
      if (commit)              wd <= '0;
      else if (run && !expire) wd <= wd + 1'b1;
      // x10 as seen before the ebreak retires
      if (commit && is_ebreak) trap_ok <= (regs[10] == 32'd0);
    end
  end

  assign rf_0  = 32'd0;
  assign rf_1  = regs[1];
  assign rf_2  = regs[2];
  assign rf_3  = regs[3];
  assign rf_4  = regs[4];
  assign rf_5  = regs[5];
  assign rf_6  = regs[6];
  assign rf_7  = regs[7];
  assign rf_8  = regs[8];
  assign rf_9  = regs[9];
  assign rf_10 = regs[10];
  assign rf_11 = regs[11];
  assign rf_12 = regs[12];
  assign rf_13 = regs[13];
  assign rf_14 = regs[14];
  assign rf_15 = regs[15];
  assign rf_16 = regs[16];
  assign rf_17 = regs[17];
  assign rf_18 = regs[18];
  assign rf_19 = regs[19];
  assign rf_20 = regs[20];
  assign rf_21 = regs[21];
  assign rf_22 = regs[22];
  assign rf_23 = regs[23];
  assign rf_24 = regs[24];
  assign rf_25 = regs[25];
  assign rf_26 = regs[26];
  assign rf_27 = regs[27];
  assign rf_28 = regs[28];
  assign rf_29 = regs[29];
  assign rf_30 = regs[30];
  assign rf_31 = regs[31];

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor with a 16-cycle watchdog.
// Drives the retire bus after each rising edge and samples 1ns later.
module tb_commit_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_rf_we = 1'b0;
  logic [4:0]  wb_rf_waddr = '0;
  logic [31:0] wb_rf_wdata = '0;
  logic        dt_valid;
  logic [31:0] dt_pc;
  logic [31:0] rf [32];
  logic [63:0] inst_cnt;
  logic [63:0] cycle_cnt;
  logic        halt;
  logic        good_trap;
  logic        timeout;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] ADDI = 32'h0000_0013;

  always #5 clk = ~clk;

  commit_monitor #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_inst(wb_inst), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
    .wb_rf_wdata(wb_rf_wdata), .dt_valid(dt_valid), .dt_pc(dt_pc),
    .rf_0(rf[0]), .rf_1(rf[1]), .rf_2(rf[2]), .rf_3(rf[3]),
    .rf_4(rf[4]), .rf_5(rf[5]), .rf_6(rf[6]), .rf_7(rf[7]),
    .rf_8(rf[8]), .rf_9(rf[9]), .rf_10(rf[10]), .rf_11(rf[11]),
    .rf_12(rf[12]), .rf_13(rf[13]), .rf_14(rf[14]), .rf_15(rf[15]),
    .rf_16(rf[16]), .rf_17(rf[17]), .rf_18(rf[18]), .rf_19(rf[19]),
    .rf_20(rf[20]), .rf_21(rf[21]), .rf_22(rf[22]), .rf_23(rf[23]),
    .rf_24(rf[24]), .rf_25(rf[25]), .rf_26(rf[26]), .rf_27(rf[27]),
    .rf_28(rf[28]), .rf_29(rf[29]), .rf_30(rf[30]), .rf_31(rf[31]),
    .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt), .halt(halt),
    .good_trap(good_trap), .timeout(timeout)
  );

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    wb_valid = v; wb_pc = pc; wb_inst = inst;
    wb_rf_we = we; wb_rf_waddr = wa; wb_rf_wdata = wd;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset;
    wb_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    wb_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (dt_valid !== 1'b0) begin bad++; $display("FAIL rst_dtv got=%0h want=0", dt_valid); end
    total++; if (dt_pc !== 32'h8000_0000) begin bad++; $display("FAIL rst_pc got=%h want=80000000", dt_pc); end
    total++; if (inst_cnt !== 64'd0 || cycle_cnt !== 64'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", inst_cnt, cycle_cnt); end
    total++; if ({halt, good_trap, timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {halt, good_trap, timeout}); end
    total++; if (rf[5] !== 32'd0 || rf[31] !== 32'd0) begin bad++; $display("FAIL rst_rf got=%h/%h want=0/0", rf[5], rf[31]); end
    rst_n = 1'b1;
  endtask

  task automatic test_commit;
    do_reset();
    cyc(1'b1, 32'h8000_0000, 32'h0000_0293, 1'b1, 5'd5, 32'h1234);
    total++; if (dt_valid !== 1'b1) begin bad++; $display("FAIL c1_dtv got=%0h want=1", dt_valid); end
    total++; if (dt_pc !== 32'h8000_0000) begin bad++; $display("FAIL c1_pc got=%h want=80000000", dt_pc); end
    total++; if (rf[5] !== 32'h1234) begin bad++; $display("FAIL c1_rf5 got=%h want=00001234", rf[5]); end
    total++; if (inst_cnt !== 64'd1 || cycle_cnt !== 64'd1) begin bad++; $display("FAIL c1_cnt got=%0d/%0d want=1/1", inst_cnt, cycle_cnt); end
    idle(1);
    total++; if (dt_valid !== 1'b0) begin bad++; $display("FAIL c1_pulse got=%0h want=0", dt_valid); end
    cyc(1'b1, 32'h8000_0004, ADDI, 1'b1, 5'd0, 32'hFFFF_FFFF);
    total++; if (rf[0] !== 32'd0) begin bad++; $display("FAIL x0_rf0 got=%h want=0", rf[0]); end
    total++; if (dt_valid !== 1'b1 || dt_pc !== 32'h8000_0004) begin bad++; $display("FAIL x0_dt got=%0h/%h want=1/80000004", dt_valid, dt_pc); end
    total++; if (inst_cnt !== 64'd2 || cycle_cnt !== 64'd3) begin bad++; $display("FAIL x0_cnt got=%0d/%0d want=2/3", inst_cnt, cycle_cnt); end
    total++; if (rf[5] !== 32'h1234) begin bad++; $display("FAIL x0_rf5 got=%h want=00001234", rf[5]); end
  endtask

  task automatic test_ebreak(input logic [31:0] x10, input logic gt);
    do_reset();
    cyc(1'b1, 32'h8000_0000, ADDI, 1'b1, 5'd10, x10);
    cyc(1'b1, 32'h8000_0004, EBRK, 1'b0, 5'd0, 32'd0);
    total++; if (halt !== 1'b1 || good_trap !== gt) begin bad++; $display("FAIL eb_flags got=%b%b want=1%b", halt, good_trap, gt); end
    total++; if (dt_valid !== 1'b1 || dt_pc !== 32'h8000_0004) begin bad++; $display("FAIL eb_dt got=%0h/%h want=1/80000004", dt_valid, dt_pc); end
    total++; if (inst_cnt !== 64'd2 || timeout !== 1'b0) begin bad++; $display("FAIL eb_cnt got=%0d/%0h want=2/0", inst_cnt, timeout); end
    cyc(1'b1, 32'h8000_0008, ADDI, 1'b1, 5'd5, 32'h55);
    total++; if (dt_valid !== 1'b0 || dt_pc !== 32'h8000_0004) begin bad++; $display("FAIL eb_ign_dt got=%0h/%h want=0/80000004", dt_valid, dt_pc); end
    total++; if (inst_cnt !== 64'd2 || rf[5] !== 32'd0) begin bad++; $display("FAIL eb_ign got=%0d/%h want=2/0", inst_cnt, rf[5]); end
    idle(20);
    total++; if (cycle_cnt !== 64'd2 || timeout !== 1'b0) begin bad++; $display("FAIL eb_hold got=%0d/%0h want=2/0", cycle_cnt, timeout); end
    total++; if (halt !== 1'b1 || good_trap !== gt || rf[10] !== x10) begin bad++; $display("FAIL eb_sticky got=%b%b/%h want=1%b/%h", halt, good_trap, rf[10], gt, x10); end
  endtask

  task automatic test_timeout;
    do_reset();
    idle(15);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%0h want=0", timeout); end
    idle(1);
    total++; if (timeout !== 1'b1 || halt !== 1'b0) begin bad++; $display("FAIL to_fire got=%0h/%0h want=1/0", timeout, halt); end
    total++; if (cycle_cnt !== 64'd16) begin bad++; $display("FAIL to_cyc got=%0d want=16", cycle_cnt); end
    cyc(1'b1, 32'h8000_0000, ADDI, 1'b1, 5'd3, 32'h9);
    idle(3);
    total++; if (cycle_cnt !== 64'd16 || inst_cnt !== 64'd0 || rf[3] !== 32'd0) begin bad++; $display("FAIL to_hold got=%0d/%0d/%h want=16/0/0", cycle_cnt, inst_cnt, rf[3]); end
    total++; if (timeout !== 1'b1 || dt_valid !== 1'b0) begin bad++; $display("FAIL to_sticky got=%0h/%0h want=1/0", timeout, dt_valid); end
  endtask

  task automatic test_expiry_commit;
    do_reset();
    idle(15);
    cyc(1'b1, 32'h8000_0000, ADDI, 1'b0, 5'd0, 32'd0);
    total++; if (timeout !== 1'b0 || inst_cnt !== 64'd1) begin bad++; $display("FAIL ex_save got=%0h/%0d want=0/1", timeout, inst_cnt); end
    idle(15);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL ex_early got=%0h want=0", timeout); end
    idle(1);
    total++; if (timeout !== 1'b1 || cycle_cnt !== 64'd32) begin bad++; $display("FAIL ex_fire got=%0h/%0d want=1/32", timeout, cycle_cnt); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    cyc(1'b1, 32'h8000_0000, ADDI, 1'b1, 5'd5, 32'h1);
    cyc(1'b1, 32'h8000_0004, ADDI, 1'b1, 5'd6, 32'h2);
    wb_valid = 1'b1; wb_pc = 32'h8000_0008; wb_inst = ADDI;
    wb_rf_we = 1'b1; wb_rf_waddr = 5'd7; wb_rf_wdata = 32'h3;
    #2 rst_n = 1'b0;
    #1;
    total++; if (dt_valid !== 1'b0 || dt_pc !== 32'h8000_0000) begin bad++; $display("FAIL b2b_async got=%0h/%h want=0/80000000", dt_valid, dt_pc); end
    total++; if (inst_cnt !== 64'd0 || cycle_cnt !== 64'd0 || rf[5] !== 32'd0 || rf[6] !== 32'd0) begin bad++; $display("FAIL b2b_clr got=%0d/%0d/%h/%h want=0", inst_cnt, cycle_cnt, rf[5], rf[6]); end
    @(posedge clk); #1;
    total++; if (dt_valid !== 1'b0 || inst_cnt !== 64'd0 || rf[7] !== 32'd0) begin bad++; $display("FAIL b2b_held got=%0h/%0d/%h want=0/0/0", dt_valid, inst_cnt, rf[7]); end
    wb_valid = 1'b0;
    rst_n = 1'b1;
    idle(1);
    total++; if (dt_valid !== 1'b0 || inst_cnt !== 64'd0) begin bad++; $display("FAIL b2b_post got=%0h/%0d want=0/0", dt_valid, inst_cnt); end
    cyc(1'b1, 32'h8000_0000, ADDI, 1'b1, 5'd7, 32'h3);
    total++; if (inst_cnt !== 64'd1 || rf[7] !== 32'h3 || dt_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0d/%h/%0h want=1/3/1", inst_cnt, rf[7], dt_valid); end
  endtask

  initial begin
    #2;
    test_reset();
    test_commit();
    test_ebreak(32'd0, 1'b1);
    test_ebreak(32'd7, 1'b0);
    test_timeout();
    test_expiry_commit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
